// File: rtl/ex_divider_pkg.sv
// Shared CPU constants: ALU_SELECT opcodes and divider opcode decode helpers.
// Pure constants and functions, no clocked logic.
// Imported by the EX-stage divider and its bus interface.
package ex_divider_pkg;

  localparam logic [5:0] ALU_DIV  = 6'b011100;
  localparam logic [5:0] ALU_DIVU = 6'b011101;
  localparam logic [5:0] ALU_REM  = 6'b011110;
  localparam logic [5:0] ALU_REMU = 6'b011111;

  localparam logic [5:0] DIV_CNT_INIT = 6'd32;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [5:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_divider_if.sv
// EX-stage divider bus: opcode/operands from ID/EX, stall/done/result back.
// Wires only, no latency.
// DIV_STALL is the backpressure towards PC and the pipeline registers.
interface ex_divider_if;

  logic [5:0]  EX_ALU_SELECT;
  logic [31:0] EX_REG_DATA1;
  logic [31:0] EX_REG_DATA2;
  logic        DIV_STALL;
  logic        DIV_DONE;
  logic [31:0] DIV_RESULT;

  modport master (
    output EX_ALU_SELECT, EX_REG_DATA1, EX_REG_DATA2,
    input  DIV_STALL, DIV_DONE, DIV_RESULT
  );

  modport slave (
    input  EX_ALU_SELECT, EX_REG_DATA1, EX_REG_DATA2,
    output DIV_STALL, DIV_DONE, DIV_RESULT
  );

endinterface

// File: rtl/ex_divider_div_step.sv
// One restoring-division step on unsigned magnitudes.
// Purely combinational, zero latency.
// No flow control; the caller sequences the steps.
module ex_divider_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] rem_shift;
  logic [32:0] diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    rem_shift = {rem_i, quo_i[31]};
    diff      = rem_shift - {1'b0, dvs_i};
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = rem_shift[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_divider.sv
// Multi-cycle EX-stage divider (DIV/DIVU/REM/REMU), macro DIV_FAST_SPECIAL_EN.
// Latency 34 cycles (1 IDLE + 32 CALC + 1 DONE); 2 for /0 and overflow when the macro is set.
// DIV_STALL holds the pipeline from the IDLE start cycle until DONE.
module ex_divider
  import ex_divider_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  ex_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic [31:0] result_q, result_d;

  // Incoming operand decode: sign handling and special-case detection.
  logic        start;
  logic        in_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, sgn_ovf;
  logic [31:0] spec_res;

  // Step datapath and sign post-processing of the final step.
  logic [31:0] step_rem, step_quo;
  logic [31:0] quo_fix, rem_fix, calc_res;

  // Operand pre-processing: magnitudes, sign flags and special results.
  always_comb begin
    start     = is_div_op(bus.EX_ALU_SELECT);
    in_signed = is_signed_op(bus.EX_ALU_SELECT);
    a_neg     = in_signed && bus.EX_REG_DATA1[31];
    b_neg     = in_signed && bus.EX_REG_DATA2[31];
    a_mag     = a_neg ? -bus.EX_REG_DATA1 : bus.EX_REG_DATA1;
    b_mag     = b_neg ? -bus.EX_REG_DATA2 : bus.EX_REG_DATA2;
    div_zero  = (bus.EX_REG_DATA2 == 32'h0);
    sgn_ovf   = in_signed && (bus.EX_REG_DATA1 == 32'h8000_0000) &&
                (bus.EX_REG_DATA2 == 32'hFFFF_FFFF);
    // Divide-by-zero takes precedence; overflow only applies with a nonzero divisor.
    spec_res  = 32'h0;
    if (div_zero) begin
      spec_res = is_rem_op(bus.EX_ALU_SELECT) ? bus.EX_REG_DATA1 : 32'hFFFF_FFFF;
    end else if (sgn_ovf) begin
      spec_res = is_rem_op(bus.EX_ALU_SELECT) ? 32'h0 : 32'h8000_0000;
    end
  end

  ex_divider_div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Sign post-processing of the last step's quotient and remainder.
  always_comb begin
    quo_fix  = neg_quo_q ? -step_quo : step_quo;
    rem_fix  = neg_rem_q ? -step_rem : step_rem;
    calc_res = spec_q ? spec_res_q : (is_rem_op(op_q) ? rem_fix : quo_fix);
  end

  // Next-state and datapath load logic for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = bus.EX_ALU_SELECT;
          quo_d      = a_mag;
          rem_d      = 32'h0;
          dvs_d      = b_mag;
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          spec_d     = div_zero || sgn_ovf;
          spec_res_d = spec_res;
          cnt_d      = DIV_CNT_INIT;
          state_d    = S_CALC;
`ifdef DIV_FAST_SPECIAL_EN
          if (div_zero || sgn_ovf) begin
            cnt_d    = 6'd0;
            result_d = spec_res;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          result_d = calc_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any opcode present.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      op_q       <= 6'd0;
      quo_q      <= 32'h0;
      rem_q      <= 32'h0;
      dvs_q      <= 32'h0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'h0;
      result_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
    end
  end

  // Stall is combinational on the opcode in IDLE so the start cycle is held too.
  assign bus.DIV_STALL  = !RESET && (((state_q == S_IDLE) && start) || (state_q == S_CALC));
  assign bus.DIV_DONE   = !RESET && (state_q == S_DONE);
  assign bus.DIV_RESULT = result_q;

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed corner cases plus random ops.
// Expected values come from a plain-arithmetic reference of the division rules.
module tb_ex_divider;
  import ex_divider_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  ex_divider_if bus ();

  ex_divider u_dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    bit sg, rm;
    sg = (op == ALU_DIV) || (op == ALU_REM);
    rm = (op == ALU_REM) || (op == ALU_REMU);
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sg) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return rm ? r : q;
  endfunction

  function automatic int ref_stalls(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    bit special;
    special = (b == 32'h0) ||
              (((op == ALU_DIV) || (op == ALU_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that follows DONE.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int done_cyc);
    int stalls;
    bit seen;
    logic [31:0] exp;
    exp      = ref_div(op, a, b);
    stalls   = 0;
    seen     = 0;
    res      = 32'h0;
    done_cyc = -1;
    bus.EX_ALU_SELECT = op;
    bus.EX_REG_DATA1  = a;
    bus.EX_REG_DATA2  = b;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.DIV_DONE) begin
        seen     = 1;
        res      = bus.DIV_RESULT;
        done_cyc = cyc;
        chk({tag, "_res"}, bus.DIV_RESULT, exp);
        chk({tag, "_stall_in_done"}, {31'b0, bus.DIV_STALL}, 32'd0);
      end else if (bus.DIV_STALL) begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (!seen) begin
        bus.EX_REG_DATA1 = $urandom;
        bus.EX_REG_DATA2 = $urandom;
      end
    end
    chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, "_stalls"}, stalls, ref_stalls(op, a, b));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    logic [31:0] last_res;
    logic [5:0]  op;
    int d1, d2;
    int dones;
    n_tests = 0;
    n_fail  = 0;

    // Reset held while a div opcode is present: reset must win.
    rst = 1'b1;
    bus.EX_ALU_SELECT = ALU_DIV;
    bus.EX_REG_DATA1  = 32'd5;
    bus.EX_REG_DATA2  = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, bus.DIV_STALL}, 32'd0);
    chk("rst_done", {31'b0, bus.DIV_DONE}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.EX_ALU_SELECT = 6'd0;
    @(negedge clk);
    chk("post_rst_stall", {31'b0, bus.DIV_STALL}, 32'd0);
    chk("post_rst_done", {31'b0, bus.DIV_DONE}, 32'd0);
    chk("post_rst_result", bus.DIV_RESULT, 32'd0);
    @(posedge clk);
    #1;

    // Non-div opcodes are ignored.
    for (int i = 0; i < 6; i++) begin
      do op = 6'($urandom); while (is_div_op(op));
      bus.EX_ALU_SELECT = op;
      bus.EX_REG_DATA1  = $urandom;
      bus.EX_REG_DATA2  = $urandom;
      @(negedge clk);
      chk("nondiv_stall", {31'b0, bus.DIV_STALL}, 32'd0);
      chk("nondiv_done", {31'b0, bus.DIV_DONE}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Directed corner cases, issued back to back.
    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, res, d1);
    chk("divu_100_7_lit", res, 32'd14);
    run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, res, d1);
    chk("remu_100_7_lit", res, 32'd2);
    run_op("div_m7_2", ALU_DIV, -32'sd7, 32'd2, res, d1);
    chk("div_m7_2_lit", res, 32'hFFFF_FFFD);
    run_op("rem_m7_2", ALU_REM, -32'sd7, 32'd2, res, d1);
    chk("rem_m7_2_lit", res, 32'hFFFF_FFFF);
    run_op("div_5_0", ALU_DIV, 32'd5, 32'd0, res, d1);
    chk("div_5_0_lit", res, 32'hFFFF_FFFF);
    run_op("rem_5_0", ALU_REM, 32'd5, 32'd0, res, d1);
    chk("rem_5_0_lit", res, 32'd5);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, d1);
    chk("div_ovf_lit", res, 32'h8000_0000);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, d1);
    chk("rem_ovf_lit", res, 32'd0);

    // Back-to-back spacing between DONE pulses.
    run_op("b2b_first", ALU_DIVU, 32'd100, 32'd7, res, d1);
    chk("b2b_first_lit", res, 32'd14);
    run_op("b2b_second", ALU_DIVU, 32'd9, 32'd3, res, d2);
    chk("b2b_second_lit", res, 32'd3);
    chk("b2b_spacing", d2 - d1, 32'd34);
    last_res = res;

    // Result holds and DONE stays low once the pipeline moves on.
    bus.EX_ALU_SELECT = 6'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_result", bus.DIV_RESULT, last_res);
      chk("hold_done", {31'b0, bus.DIV_DONE}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Reset during CALC aborts without a DONE pulse.
    bus.EX_ALU_SELECT = ALU_DIVU;
    bus.EX_REG_DATA1  = 32'd100;
    bus.EX_REG_DATA2  = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.EX_ALU_SELECT = 6'd0;
    @(negedge clk);
    chk("abort_stall", {31'b0, bus.DIV_STALL}, 32'd0);
    chk("abort_done", {31'b0, bus.DIV_DONE}, 32'd0);
    chk("abort_result", bus.DIV_RESULT, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.DIV_DONE) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    @(posedge clk);
    #1;

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = ALU_DIV + 6'($urandom_range(0, 3));
      run_op("rand", op, pick_operand(), pick_operand(), res, d1);
    end
    bus.EX_ALU_SELECT = 6'd0;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_divider.md
EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port EX_ALU_SELECT  input  6  operation code taken from the ID/EX pipeline register output.
REQ-004 SHALL have port EX_REG_DATA1  input  32  dividend, rs1 value from ID/EX.
REQ-005 SHALL have port EX_REG_DATA2  input  32  divisor, rs2 value from ID/EX.
REQ-006 SHALL have port DIV_STALL  output  1  hold request to PC and IF/ID, ID/EX, EX/MEM pipeline registers.
REQ-007 SHALL have port DIV_DONE  output  1  one-cycle pulse; DIV_RESULT is valid for this instruction.
REQ-008 SHALL have port DIV_RESULT  output  32  quotient or remainder, per the latched opcode.

Function
REQ-009 SHALL recognise the four opcodes ALU_DIV=6'b011100, ALU_DIVU=6'b011101, ALU_REM=6'b011110 and ALU_REMU=6'b011111; all other codes are ignored.
REQ-010 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-011 IDLE with a div opcode: SHALL latch the operand magnitudes, the opcode and the result-sign flags, load a 6-bit counter with 32, and go to CALC; DIV_STALL SHALL be high combinationally in this same cycle.
REQ-012 CALC: SHALL perform one restoring shift/subtract step per cycle, decrementing the counter; on the step with counter==1 it SHALL go to DONE; DIV_STALL SHALL be high throughout.
REQ-013 DONE: SHALL drive DIV_DONE=1 and DIV_STALL=0 with DIV_RESULT valid, then return to IDLE unconditionally; the still-present opcode SHALL NOT restart the operation.
REQ-014 Normal latency: 1 IDLE + 32 CALC + 1 DONE = 34 cycles with the instruction in EX, of which DIV_STALL is high for 33.
REQ-015 Signed ops: SHALL divide magnitudes; the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
REQ-016 Divide by zero: quotient SHALL be 32'hFFFFFFFF and remainder SHALL be the dividend, for both signed and unsigned ops.
REQ-017 Signed overflow (32'h80000000 / 32'hFFFFFFFF): quotient SHALL be 32'h80000000 and remainder SHALL be 0.
REQ-018 DIV_RESULT SHALL hold its last value outside DONE; DIV_DONE SHALL be 0 outside DONE.
REQ-019 Back-to-back div instructions: the IDLE cycle after DONE SHALL start the next division, giving no bubble other than the mandatory IDLE cycle.
REQ-020 Operand changes on EX_REG_DATA1/2 during CALC SHALL be ignored; only the values latched in IDLE are used.

Reset
REQ-021 RESET SHALL take priority over all other inputs, including an opcode present in the same cycle.
REQ-022 After RESET: state IDLE, counter 0, DIV_STALL=0, DIV_DONE=0, DIV_RESULT=32'b0.
REQ-023 RESET asserted during CALC or DONE SHALL abort the operation with no DONE pulse.

Configuration
REQ-024 Macro DIV_FAST_SPECIAL_EN defined: divide-by-zero and signed overflow SHALL go IDLE->DONE directly, giving a 2-cycle latency with DIV_STALL high for 1 cycle.
REQ-025 Macro DIV_FAST_SPECIAL_EN undefined: those cases SHALL take the full 34 cycles; result values SHALL be identical in both configurations.

Structure
REQ-026 The ALU_SELECT opcode constants, including the four div codes, SHALL live in the shared cpu constants package; the FSM state encodings SHALL be local to the module.
REQ-027 The sign pre/post-processing (abs, negate) SHALL be combinational logic inside the module; one sub-module, div_step (single restoring-division step), is natural.

Verification
REQ-028 DIVU 100/7: DIV_STALL high for 33 cycles, then DIV_DONE with DIV_RESULT=14; REMU 100/7 gives 2.
REQ-029 DIV -7/2 gives 32'hFFFFFFFD (-3); REM -7/2 gives 32'hFFFFFFFF (-1).
REQ-030 DIV 5/0 gives 32'hFFFFFFFF and REM 5/0 gives 5; with DIV_FAST_SPECIAL_EN, DONE arrives on cycle 2.
REQ-031 DIV 32'h80000000/32'hFFFFFFFF gives 32'h80000000; the matching REM gives 0.
REQ-032 RESET pulsed at CALC cycle 10: the next cycle shows DIV_STALL=0, no DONE pulse, and DIV_RESULT=0.
REQ-033 Two consecutive DIVU ops (100/7 then 9/3): DONE pulses 34 cycles apart, with results 14 then 3.
